// File: rtl/imem_arb.sv
// imem_arb: shares the single-port instruction memory between the core fetch
// port (read-only) and the loader/debug port (read/write). One access per
// cycle, round-robin on conflict, response routed back one cycle later.
// Optional feature macro: IMEM_ARB_BOOT_HOLD_EN (BOOT state holds fetch off
// until the loader signals i_l_done).
module imem_arb #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_f_req,
  input  logic [31:0]       i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_rvalid,
  output logic [31:0]       o_f_rdata,
  output logic              o_f_err,
  input  logic              i_l_req,
  input  logic              i_l_we,
  input  logic [31:0]       i_l_addr,
  input  logic [31:0]       i_l_wdata,
  input  logic              i_l_done,
  output logic              o_l_gnt,
  output logic              o_l_rvalid,
  output logic [31:0]       o_l_rdata,
  output logic              o_l_err,
  output logic              o_boot_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic run;
  logic last_l;      // 1: loader was granted last, so fetch wins next conflict
  logic f_oor, f_err, l_oor;
  logic rsp_valid, rsp_owner_l, rsp_err, rsp_rd;
  logic unused_l_lo;

  // Loader byte-offset bits carry no meaning for word accesses
  assign unused_l_lo = ^i_l_addr[1:0];

`ifdef IMEM_ARB_BOOT_HOLD_EN
  typedef enum logic {BOOT, RUN} state_t;
  state_t state_q, state_d;

  // State register: BOOT after reset
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next state: leave BOOT on i_l_done, RUN is terminal until reset
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && i_l_done) state_d = RUN;
  end

  assign run         = (state_q == RUN);
  assign o_boot_busy = (state_q == BOOT);
`else
  logic unused_done;
  assign unused_done = i_l_done;
  assign run         = 1'b1;
  assign o_boot_busy = 1'b0;
`endif

  // Range check against DEPTH on the word index; identical to testing the
  // address bits above ADDR_W+1 for zero when DEPTH is a power of two.
  assign f_oor = ({2'b00, i_f_addr[31:2]} >= DEPTH_W);
  assign l_oor = ({2'b00, i_l_addr[31:2]} >= DEPTH_W);
  assign f_err = f_oor | (|i_f_addr[1:0]);

  // Round-robin grant; everything held off while reset is asserted
  always_comb begin
    o_f_gnt = 1'b0;
    o_l_gnt = 1'b0;
    if (rst_n) begin
      if (i_f_req && run && i_l_req) begin
        o_f_gnt = last_l;
        o_l_gnt = !last_l;
      end else begin
        o_f_gnt = i_f_req && run;
        o_l_gnt = i_l_req;
      end
    end
  end

  // Memory-side drive from the winner; erroring or idle cycles drive zeros
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_f_gnt && !f_err) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_f_addr[ADDR_W+1:2];
    end else if (o_l_gnt && !l_oor) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_l_we;
      o_mem_addr  = i_l_addr[ADDR_W+1:2];
      o_mem_wdata = i_l_wdata;
    end
  end

  // Last-granted pointer, moves only on a grant
  always_ff @(posedge clk) begin
    if (!rst_n)       last_l <= 1'b1;
    else if (o_f_gnt) last_l <= 1'b0;
    else if (o_l_gnt) last_l <= 1'b1;
  end

  // Response tracking captured at the grant edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_owner_l <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rd      <= 1'b0;
    end else begin
      rsp_valid   <= o_f_gnt | o_l_gnt;
      rsp_owner_l <= o_l_gnt;
      rsp_err     <= o_f_gnt ? f_err : (o_l_gnt & l_oor);
      rsp_rd      <= o_f_gnt ? !f_err : (o_l_gnt & !l_oor & !i_l_we);
    end
  end

  assign o_f_rvalid = rsp_valid & !rsp_owner_l;
  assign o_l_rvalid = rsp_valid &  rsp_owner_l;
  assign o_f_err    = o_f_rvalid & rsp_err;
  assign o_l_err    = o_l_rvalid & rsp_err;
  assign o_f_rdata  = (o_f_rvalid && rsp_rd) ? i_mem_rdata : '0;
  assign o_l_rdata  = (o_l_rvalid && rsp_rd) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_imem_arb.sv
// Directed self-checking bench for imem_arb with a 1-cycle-read memory model.
module tb_imem_arb;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              f_req, l_req, l_we, l_done;
  logic [31:0]       f_addr, l_addr, l_wdata;
  logic              f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
  logic [31:0]       f_rdata, l_rdata;
  logic              boot_busy, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       mem [DEPTH];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  imem_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata), .o_f_err(f_err),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .i_l_done(l_done), .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid),
    .o_l_rdata(l_rdata), .o_l_err(l_err), .o_boot_busy(boot_busy),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Single-port memory, registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    logic [31:0] wx [4];
    logic [31:0] fa [3];
    logic [31:0] fd [3];
    logic        exp_f;
    wa = '{32'h0000_0004, 32'h0000_0008, 32'h0000_1FFC, 32'h0000_0010};
    wd = '{32'h1111_0004, 32'h2222_0008, 32'h7FF7_FF00, 32'h4444_0010};
    wx = '{32'd1, 32'd2, 32'd2047, 32'd4};
    fa = '{32'h0, 32'h4, 32'h8};
    fd = '{32'h0000_0013, 32'h1111_0004, 32'h2222_0008};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0; f_req = 1'b1; f_addr = '0; l_req = 1'b1; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_done = 1'b0;

    // Reset: grants and memory enable forced low, responses idle
    cycle(); #2;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    cycle();
    rst_n = 1'b1; f_req = 1'b0; l_req = 1'b0;

`ifdef IMEM_ARB_BOOT_HOLD_EN
    f_req = 1'b1; f_addr = 32'h0;
    #2;
    chk("boot_f_gnt0", f_gnt, 0);
    chk("boot_busy0", boot_busy, 1);
    chk("boot_mem_en0", mem_en, 0);
    cycle(); #2;
    chk("boot_f_gnt1", f_gnt, 0);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h0000_0013;
    #1;
    chk("boot_l_gnt", l_gnt, 1);
    chk("boot_f_gnt2", f_gnt, 0);
    chk("boot_mem_we", mem_we, 1);
    cycle();
    l_req = 1'b0; l_done = 1'b1;
    #2;
    chk("boot_wr_ack", l_rvalid, 1);
    chk("boot_done_f_gnt", f_gnt, 0);
    chk("boot_done_busy", boot_busy, 1);
    cycle();
    l_done = 1'b0;
    #2;
    chk("run_f_gnt", f_gnt, 1);
    chk("run_busy", boot_busy, 0);
    chk("run_mem_addr", mem_addr, 0);
    cycle();
    f_req = 1'b0;
    chk("boot_f_rvalid", f_rvalid, 1);
    chk("boot_f_rdata", f_rdata, 32'h0000_0013);
    chk("boot_f_err", f_err, 0);
`else
    // No boot hold: fetch wins the first conflict straight out of reset
    f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h0000_0013;
    #2;
    chk("first_f_gnt", f_gnt, 1);
    chk("first_l_gnt", l_gnt, 0);
    chk("first_busy", boot_busy, 0);
    cycle();
    f_req = 1'b0;
    chk("first_f_rvalid", f_rvalid, 1);
    chk("first_f_rdata", f_rdata, 0);
    #2;
    chk("first_l_gnt2", l_gnt, 1);
    chk("first_mem_we", mem_we, 1);
    cycle();
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'h0;
    chk("first_l_rvalid", l_rvalid, 1);
    chk("first_l_rdata", l_rdata, 0);
    #2;
    chk("first_f_gnt2", f_gnt, 1);
    cycle();
    f_req = 1'b0;
    chk("first_f_rvalid2", f_rvalid, 1);
    chk("first_f_rdata2", f_rdata, 32'h0000_0013);
`endif

    // Back-to-back loader writes, last one is the write-ack case at 0x10
    l_req = 1'b1; l_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l_addr = wa[i]; l_wdata = wd[i];
      #2;
      chk("wr_l_gnt", l_gnt, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, wx[i]);
      cycle();
      chk("wr_l_rvalid", l_rvalid, 1);
      chk("wr_l_rdata", l_rdata, 0);
      chk("wr_l_err", l_err, 0);
    end

    // Conflict: fetch 0x4 vs loader read 0x8, grants alternate F,L,F,L
    f_req = 1'b1; f_addr = 32'h4; l_we = 1'b0; l_addr = 32'h8;
    for (int k = 0; k < 4; k++) begin
      exp_f = ((k % 2) == 0);
      #2;
      chk("cf_f_gnt", f_gnt, exp_f);
      chk("cf_l_gnt", l_gnt, !exp_f);
      chk("cf_mem_addr", mem_addr, exp_f ? 32'd1 : 32'd2);
      cycle();
      chk("cf_f_rvalid", f_rvalid, exp_f);
      chk("cf_l_rvalid", l_rvalid, !exp_f);
      chk("cf_f_rdata", f_rdata, exp_f ? 32'h1111_0004 : 32'h0);
      chk("cf_l_rdata", l_rdata, exp_f ? 32'h0 : 32'h2222_0008);
    end
    l_req = 1'b0;

    // Back-to-back fetches, loader idle
    for (int i = 0; i < 3; i++) begin
      f_addr = fa[i];
      #2;
      chk("b2b_f_gnt", f_gnt, 1);
      cycle();
      chk("b2b_f_rvalid", f_rvalid, 1);
      chk("b2b_f_rdata", f_rdata, fd[i]);
    end

    // Fetch errors: out of range, then misaligned
    f_addr = 32'h0000_2000;
    #2;
    chk("oor_f_gnt", f_gnt, 1);
    chk("oor_mem_en", mem_en, 0);
    cycle();
    chk("oor_f_rvalid", f_rvalid, 1);
    chk("oor_f_err", f_err, 1);
    chk("oor_f_rdata", f_rdata, 0);
    f_addr = 32'h0000_0006;
    #2;
    chk("mis_mem_en", mem_en, 0);
    cycle();
    chk("mis_f_rvalid", f_rvalid, 1);
    chk("mis_f_err", f_err, 1);
    chk("mis_f_rdata", f_rdata, 0);

    // Last word is in range
    f_addr = 32'h0000_1FFC;
    #2;
    chk("top_mem_addr", mem_addr, 32'd2047);
    chk("top_mem_en", mem_en, 1);
    cycle();
    f_req = 1'b0;
    chk("top_f_err", f_err, 0);
    chk("top_f_rdata", f_rdata, 32'h7FF7_FF00);

    // Loader out-of-range read, then read with low bits set (ignored)
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8000_0008;
    #2;
    chk("l_oor_gnt", l_gnt, 1);
    chk("l_oor_mem_en", mem_en, 0);
    cycle();
    chk("l_oor_rvalid", l_rvalid, 1);
    chk("l_oor_err", l_err, 1);
    chk("l_oor_rdata", l_rdata, 0);
    l_addr = 32'h0000_0009;
    #2;
    chk("l_lo_mem_addr", mem_addr, 32'd2);
    cycle();
    l_req = 1'b0;
    chk("l_lo_err", l_err, 0);
    chk("l_lo_rdata", l_rdata, 32'h2222_0008);
    chk("l_lo_f_rvalid", f_rvalid, 0);

    // i_l_done in RUN has no effect
    l_done = 1'b1;
    #2;
    chk("done_run_busy", boot_busy, 0);
    cycle();
    l_done = 1'b0;

    // Reset mid-flight: grant a fetch, reset at the following edge
    f_req = 1'b1; f_addr = 32'h4;
    #2;
    chk("mid_f_gnt", f_gnt, 1);
    rst_n = 1'b0;
    cycle();
    chk("mid_f_rvalid", f_rvalid, 0);
    chk("mid_f_rdata", f_rdata, 0);
    chk("mid_f_err", f_err, 0);
    chk("mid_l_rvalid", l_rvalid, 0);
    chk("mid_f_gnt_rst", f_gnt, 0);
    chk("mid_mem_en", mem_en, 0);
    chk("mid_mem_addr", mem_addr, 0);
    rst_n = 1'b1; f_req = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
# imem_arb

Two-requester arbiter and sequencer in front of the single-port, 1-cycle-read instruction memory. It shares the memory between the core fetch port (read-only) and a loader/debug port (read/write), which replaces file-based preload. It issues at most one memory access per cycle and routes the registered read data back to the requester that owns it. It also screens out-of-range and misaligned accesses.

## Interface
- DEPTH, 2048: memory depth in 32-bit words
- ADDR_W, 11: word-address width, equals log2(DEPTH)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- i_f_req  in  1  fetch request
- i_f_addr  in  32  fetch byte address
- o_f_gnt  out  1  fetch granted this cycle (combinational)
- o_f_rvalid  out  1  fetch response valid
- o_f_rdata  out  32  fetch instruction word
- o_f_err  out  1  fetch error, qualified by o_f_rvalid
- i_l_req  in  1  loader request
- i_l_we  in  1  loader write (1) / read (0)
- i_l_addr  in  32  loader byte address
- i_l_wdata  in  32  loader write data
- i_l_done  in  1  loader finished preload (single-cycle pulse)
- o_l_gnt  out  1  loader granted this cycle (combinational)
- o_l_rvalid  out  1  loader response valid (read data or write ack)
- o_l_rdata  out  32  loader read data, 0 for write acks
- o_l_err  out  1  loader error, qualified by o_l_rvalid
- o_boot_busy  out  1  arbiter is in BOOT state
- o_mem_en  out  1  memory access enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory word address
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data, valid 1 cycle after en & !we

## Operation
- State machine with states BOOT and RUN. In BOOT, the fetch request is masked: o_f_gnt=0 and the loader is the only requester. In RUN, both requesters compete.
- Transition BOOT→RUN on i_l_done=1. The state is RUN from the next cycle onward. There is no RUN→BOOT transition except through reset.
- Arbitration is round-robin with a last-granted pointer.
  - Single eligible request: grant it.
  - Both requests: grant the one that is not last-granted.
  - The pointer updates only on a grant.
- Per granted request:
  - Word address = addr[ADDR_W+1:2].
  - Out-of-range when addr[31:ADDR_W+2]≠0.
  - Fetch is misaligned when addr[1:0]≠0. Loader low address bits are ignored.
- Error access: still granted, but o_mem_en=0. The response arrives the next cycle with rdata=0 and err=1.
- Valid access: o_mem_en=1 with o_mem_addr/we/wdata from the winner. Fetch always drives we=0.
- Response routing:
  - A 1-bit owner register plus an error flag is captured at the grant edge.
  - The next cycle, the owner's rvalid=1 and rdata=i_mem_rdata (reads) or 0 (writes).
  - The non-owner's rvalid=0 and its rdata=0.
- No grant means o_mem_en=0. The memory-side outputs are then don't-care, but are driven to 0.

## Timing
- Reset (rst_n=0 at an edge):
  - State = BOOT (macro on) or RUN (macro off).
  - Pointer = loader, so fetch wins the first conflict.
  - All rvalid/err/rdata = 0, owner register cleared.
  - While rst_n=0, the gnt outputs and o_mem_en are forced to 0.
- Grant latency 0: gnt and mem outputs are combinational from req in the same cycle.
- Response latency exactly 1 cycle after grant.
- Throughput 1 access per cycle, back-to-back. Each response is a 1-cycle pulse with no backpressure; requesters must accept it.
- Requesters hold req/addr until granted. Deasserting before grant is legal; nothing is issued.
- Reset mid-operation: a response due on the cycle after the reset edge is dropped (rvalid=0).
- i_l_done together with a loader request in BOOT: the request is served in BOOT. Fetch becomes eligible from the next cycle.
- i_l_done in RUN: ignored.

## Configuration
- IMEM_ARB_BOOT_HOLD_EN
  - Defined: BOOT state exists and fetch is held off after reset until i_l_done. o_boot_busy=1 in BOOT, 0 in RUN.
  - Undefined: the state machine is removed, the arbiter resets directly into RUN, i_l_done is ignored, and o_boot_busy is constant 0.

## Test plan
- Boot hold (macro on): reset, i_f_req=1 held.
  - Expected: o_f_gnt=0 and o_boot_busy=1 until i_l_done.
  - Loader writes 0x00000013 to 0x0, then pulses i_l_done. Next cycle o_f_gnt=1; one cycle later o_f_rvalid=1 with o_f_rdata=0x00000013.
- Conflict in RUN: both request every cycle, fetch addr 0x4, loader read 0x8.
  - Expected grants alternate F,L,F,L (fetch first after reset).
  - Each rvalid lands on the correct port one cycle after its grant with the matching data.
- Back-to-back fetch: 0x0, 0x4, 0x8 on consecutive cycles, loader idle.
  - Expected: three consecutive o_f_rvalid pulses, data in order, no bubbles.
- Errors:
  - Fetch 0x00002000 (DEPTH=2048): o_mem_en=0, next cycle o_f_rvalid=1, o_f_err=1, o_f_rdata=0.
  - Fetch 0x6: same response.
- Write ack: loader write to 0x10.
  - Expected: o_mem_we=1 and o_mem_addr=4 in the grant cycle; next cycle o_l_rvalid=1, o_l_rdata=0, o_l_err=0.
- Reset mid-flight: grant a fetch, assert rst_n=0 at the next edge.
  - Expected: o_f_rvalid stays 0 and all outputs read 0.
